// File: rtl/gcd_job_arbiter_if.sv
// Handshake bundle between gcd_job_arbiter, its requesters and the shared GCD core.
// The arbiter connects through the slave modport; clients and the core use master.
interface gcd_job_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
);
    // Request: job i moves on a rising edge where req_valid[i] & req_ready[i]; ready is one-hot.
    // Core: core_start is a 1-cycle pulse and core_done a 1-cycle pulse.
    // Response: resp_valid is a 1-cycle one-hot pulse with no back-pressure.
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  core_start;
    logic [WIDTH-1:0]      core_a;
    logic [WIDTH-1:0]      core_b;
    logic                  core_done;
    logic [WIDTH-1:0]      core_result;
    logic [NREQ-1:0]       resp_valid;
    logic [WIDTH-1:0]      resp_data;
    logic                  resp_err;

    modport slave (
        input  req_valid, req_a, req_b, core_done, core_result,
        output req_ready, core_start, core_a, core_b, resp_valid, resp_data, resp_err
    );

    modport master (
        output req_valid, req_a, req_b, core_done, core_result,
        input  req_ready, core_start, core_a, core_b, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/gcd_job_arbiter.sv
// Round-robin arbiter sharing one iterative GCD core among NREQ requesters.
// Optional WAIT-state abort is enabled by defining GCD_TIMEOUT_EN.
module gcd_job_arbiter #(
    parameter int NREQ           = 4,
    parameter int WIDTH          = 4,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    gcd_job_arbiter_if.slave      bus,
    output logic                  busy,
    output logic [1:0]            state_dbg
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [GW-1:0]    last_grant_q, last_grant_d;
    logic [GW-1:0]    owner_q, owner_d;
    logic [WIDTH-1:0] core_a_q, core_a_d;
    logic [WIDTH-1:0] core_b_q, core_b_d;
    logic             core_start_q, core_start_d;
    logic [NREQ-1:0]  resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0] resp_data_q, resp_data_d;
    logic             busy_q, busy_d;

`ifdef GCD_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0]    wait_cnt_q, wait_cnt_d;
    logic             resp_err_q, resp_err_d;
`endif

    logic             win_found;
    logic [GW-1:0]    win_idx;
    logic [WIDTH-1:0] win_a;
    logic [WIDTH-1:0] win_b;

    // Scan starts just after the last served requester, so every requester gets a turn.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_grant_q) + k) % NREQ;
            if (!win_found && bus.req_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = GW'(idx);
            end
        end
        win_a = bus.req_a[int'(win_idx)*WIDTH +: WIDTH];
        win_b = bus.req_b[int'(win_idx)*WIDTH +: WIDTH];
    end

    assign bus.req_ready = (reset && state_q == S_IDLE && win_found) ? (ONE << win_idx) : '0;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        core_a_d     = core_a_q;
        core_b_d     = core_b_q;
        core_start_d = 1'b0;
        resp_valid_d = '0;
        resp_data_d  = '0;
`ifdef GCD_TIMEOUT_EN
        wait_cnt_d   = wait_cnt_q;
        resp_err_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    owner_d  = win_idx;
                    core_a_d = win_a;
                    core_b_d = win_b;
                    // A zero operand makes the GCD the other operand; the core never sees it.
                    if (win_a == '0 || win_b == '0) begin
                        state_d      = S_RESP;
                        resp_valid_d = ONE << win_idx;
                        resp_data_d  = win_a | win_b;
                    end else begin
                        state_d      = S_START;
                        core_start_d = 1'b1;
                    end
                end
            end
            S_START: begin
                state_d = S_WAIT;
`ifdef GCD_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            S_WAIT: begin
                if (bus.core_done) begin
                    state_d      = S_RESP;
                    resp_valid_d = ONE << owner_q;
                    resp_data_d  = bus.core_result;
`ifdef GCD_TIMEOUT_EN
                end else if (wait_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_d      = S_RESP;
                    resp_valid_d = ONE << owner_q;
                    resp_err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
`endif
                end
            end
            S_RESP: begin
                state_d      = S_IDLE;
                last_grant_d = owner_q;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= GW'(NREQ - 1);
            owner_q      <= '0;
            core_a_q     <= '0;
            core_b_q     <= '0;
            core_start_q <= 1'b0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            busy_q       <= 1'b0;
`ifdef GCD_TIMEOUT_EN
            wait_cnt_q   <= '0;
            resp_err_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            core_a_q     <= core_a_d;
            core_b_q     <= core_b_d;
            core_start_q <= core_start_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            busy_q       <= busy_d;
`ifdef GCD_TIMEOUT_EN
            wait_cnt_q   <= wait_cnt_d;
            resp_err_q   <= resp_err_d;
`endif
        end
    end

    assign bus.core_start = core_start_q;
    assign bus.core_a     = core_a_q;
    assign bus.core_b     = core_b_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
`ifdef GCD_TIMEOUT_EN
    assign bus.resp_err   = resp_err_q;
`else
    assign bus.resp_err   = 1'b0;
`endif
    assign busy           = busy_q;
    assign state_dbg      = state_q;
endmodule

// File: tb/tb_gcd_job_arbiter.sv
// Scoreboard bench for gcd_job_arbiter: random jobs against a Euclid reference model
// and a fixed-latency core model.
module tb_gcd_job_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 4;
    localparam int TO    = 16;
    localparam int EW    = 2 + 2 + WIDTH;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       busy;
    logic [1:0] state_dbg;

    gcd_job_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    gcd_job_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT_CYCLES(TO)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    // entry = {kind, owner, data}; kind 0 = zero-operand job, 1 = core job, 2 = timeout
    logic [EW-1:0] exp_q[$];
    int            grant_log[$];
    logic [3:0]    accepted_mask = '0;
    bit            open = 0;
    int            lg = NREQ - 1;
    int            acc_cyc, start_cyc, done_cyc;
    int            cur_a, cur_b, cur_kind;
    bit            core_en = 1;
    bit            expect_to = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int gcd(int a, int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic logic [3:0] winner(logic [3:0] v, int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last + k) % NREQ]) return 4'(1 << ((last + k) % NREQ));
        end
        return 4'b0;
    endfunction

    // Monitor and scoreboard: everything is sampled mid-cycle.
    always @(negedge clock) begin
        logic [3:0]    acc;
        logic [EW-1:0] e;
        int            idx, a, b, kind, owner;
        cyc++;
        if (!reset) begin
            open = 0;
            lg   = NREQ - 1;
            exp_q.delete();
        end else begin
            chk("busy", 32'(busy), 32'(open));
            chk("req_ready", 32'(bus.req_ready), 32'(open ? 4'b0 : winner(bus.req_valid, lg)));
            if (bus.core_start) begin
                chk("start_latency", cyc, acc_cyc + 1);
                chk("core_a", 32'(bus.core_a), cur_a);
                chk("core_b", 32'(bus.core_b), cur_b);
                chk("start_nonzero_job", 32'(cur_kind != 0), 1);
                start_cyc = cyc;
            end
            if (bus.core_done) done_cyc = cyc;
            if (bus.resp_valid != 0) begin
                if (exp_q.size() == 0) begin
                    chk("resp_unexpected", 32'(bus.resp_valid), 0);
                end else begin
                    e     = exp_q.pop_front();
                    kind  = int'(e[EW-1 -: 2]);
                    owner = int'(e[WIDTH +: 2]);
                    chk("resp_valid", 32'(bus.resp_valid), 32'(1 << owner));
                    chk("resp_data", 32'(bus.resp_data), 32'(e[WIDTH-1:0]));
                    chk("resp_err", 32'(bus.resp_err), 32'(kind == 2));
                    if (kind == 0) chk("resp_latency_zero", cyc, acc_cyc + 1);
                    else if (kind == 1) chk("resp_latency_done", cyc, done_cyc + 1);
                    else chk("resp_latency_timeout", cyc, start_cyc + 1 + TO);
                    lg = owner;
                end
                open = 0;
            end
            acc = bus.req_valid & bus.req_ready;
            if (acc != 0) begin
                idx = 0;
                for (int i = 0; i < NREQ; i++) if (acc[i]) idx = i;
                a        = int'(bus.req_a[idx*WIDTH +: WIDTH]);
                b        = int'(bus.req_b[idx*WIDTH +: WIDTH]);
                kind     = (a == 0 || b == 0) ? 0 : (expect_to ? 2 : 1);
                cur_a    = a;
                cur_b    = b;
                cur_kind = kind;
                acc_cyc  = cyc;
                open     = 1;
                exp_q.push_back({2'(kind), 2'(idx), WIDTH'(kind == 2 ? 0 : gcd(a, b))});
                grant_log.push_back(idx);
                accepted_mask[idx] = 1'b1;
            end
        end
    end

    // Core model: done pulses 3 cycles after start with the true GCD.
    initial begin
        int ga, gb;
        bus.core_done   = 1'b0;
        bus.core_result = '0;
        forever begin
            @(negedge clock);
            if (bus.core_start && core_en && reset) begin
                ga = int'(bus.core_a);
                gb = int'(bus.core_b);
                repeat (3) @(posedge clock);
                #1;
                if (reset && core_en) begin
                    bus.core_done   = 1'b1;
                    bus.core_result = WIDTH'(gcd(ga, gb));
                    @(posedge clock);
                    #1 bus.core_done = 1'b0;
                end
            end
        end
    end

    task automatic set_lane(int i, int a, int b);
        bus.req_a[i*WIDTH +: WIDTH] = WIDTH'(a);
        bus.req_b[i*WIDTH +: WIDTH] = WIDTH'(b);
        bus.req_valid[i] = 1'b1;
    endtask

    task automatic issue(int i, int a, int b);
        bit got = 0;
        set_lane(i, a, b);
        for (int n = 0; n < 100 && !got; n++) begin
            @(posedge clock);
            #1;
            if (accepted_mask[i]) got = 1;
        end
        if (!got) chk("accept_timeout", 0, 1);
        bus.req_valid[i] = 1'b0;
        accepted_mask[i] = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(posedge clock);
            #1;
            if (!open) done = 1;
        end
        if (!done) chk("idle_timeout", 0, 1);
        @(posedge clock);
        #1;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;

        // Reset held: outputs stay quiet while requests toggle.
        for (int n = 0; n < 4; n++) begin
            @(posedge clock);
            #1 bus.req_valid = 4'(n % 2 == 0 ? 4'b1111 : 4'b0101);
            @(negedge clock);
            chk("rst_req_ready", 32'(bus.req_ready), 0);
            chk("rst_outputs", 32'({bus.core_start, bus.resp_valid, bus.resp_err, busy}), 0);
            chk("rst_data", 32'({bus.core_a, bus.core_b, bus.resp_data}), 0);
        end

        // All requesters valid continuously: rotation must be 0,1,2,3,0.
        @(posedge clock);
        #1;
        for (int i = 0; i < NREQ; i++) set_lane(i, 6, 4);
        reset = 1'b1;
        @(negedge clock);
        chk("first_grant", 32'(bus.req_ready), 32'(4'b0001));
        begin
            bit got = 0;
            for (int n = 0; n < 200 && !got; n++) begin
                @(posedge clock);
                #1;
                if (grant_log.size() >= 5) got = 1;
            end
            if (!got) chk("rotation_timeout", 0, 1);
        end
        bus.req_valid = '0;
        accepted_mask = '0;
        wait_idle();
        if (grant_log.size() >= 5) begin
            chk("grant_0", grant_log[0], 0);
            chk("grant_1", grant_log[1], 1);
            chk("grant_2", grant_log[2], 2);
            chk("grant_3", grant_log[3], 3);
            chk("grant_4", grant_log[4], 0);
        end

        // Directed jobs: coprime operands, then zero-operand shortcuts.
        issue(0, 15, 13); wait_idle();
        issue(2, 0, 6);   wait_idle();
        issue(1, 0, 0);   wait_idle();
        issue(3, 9, 0);   wait_idle();

        // Reset during WAIT, then a stray core_done after release.
        core_en = 0;
        issue(1, 12, 8);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_resp", 32'(bus.resp_valid), 0);
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 begin
            bus.core_done   = 1'b1;
            bus.core_result = 4'd4;
        end
        @(posedge clock);
        #1 bus.core_done = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clock);
            chk("stray_done_resp", 32'(bus.resp_valid), 0);
            chk("stray_done_busy", 32'(busy), 0);
        end
        core_en = 1;

`ifdef GCD_TIMEOUT_EN
        // Core never answers: abort after TO cycles, then a normal job.
        core_en   = 0;
        expect_to = 1;
        issue(3, 9, 6); wait_idle();
        expect_to = 0;
        core_en   = 1;
        issue(0, 9, 6); wait_idle();
`endif

        // Random traffic, including zero operands and withdrawn requests.
        for (int n = 0; n < 500; n++) begin
            @(posedge clock);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (accepted_mask[i]) begin
                    bus.req_valid[i] = 1'b0;
                    accepted_mask[i] = 1'b0;
                end else if (!bus.req_valid[i]) begin
                    if ($urandom_range(0, 3) == 0)
                        set_lane(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
                end else if ($urandom_range(0, 15) == 0) begin
                    bus.req_valid[i] = 1'b0;
                end
            end
        end
        bus.req_valid = '0;
        accepted_mask = '0;
        wait_idle();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (%0d/%0d)", passed, checks);
        $fatal(1);
    end
endmodule
